adc_fifo_drain_scheduler: RTL

// Drains the per-channel sample FIFOs of the AD9228 multi-channel readout into one tagged stream.

---
 rtl/adc_ctrl_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/adc_fifo_drain_scheduler.sv | 107 ++++++++++
 3 files changed

// File: rtl/adc_ctrl_pkg.sv
// adc_ctrl_pkg: shared types and helpers for the ADC FIFO drain scheduler.
package adc_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, READ, WAIT, OUT} drain_state_t;
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   localparam int DEF_CHANNELS   = 4;
   localparam int DEF_DATA_WIDTH = 12;
   typedef struct packed {
      logic [ch_w(DEF_CHANNELS)-1:0] ch;
      logic [DEF_DATA_WIDTH-1:0]     sample;
   } drain_word_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick over a request vector; owns the last-grant pointer.
module rr_arbiter
   import adc_ctrl_pkg::*;
#(
   parameter int N = 4,
   localparam int W = ch_w(N)
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [N-1:0] req,
   input  logic         load,
   output logic [W-1:0] grant,
   output logic         any_req
);
   logic [W-1:0] ptr_q, ptr_d;
   assign any_req = |req;
   assign ptr_d   = load ? grant : ptr_q;
   // Scan farthest-first so the nearest requester after the pointer wins.
   always_comb begin
      logic [W-1:0] idx;
      idx   = '0;
      grant = ptr_q;
      for (int i = N; i >= 1; i--) begin
         idx = W'((int'(ptr_q) + i) % N);
         if (req[idx]) grant = idx;
      end
   end
   always_ff @(posedge clk) ptr_q <= !rstn ? W'(N - 1) : ptr_d;
endmodule

// File: rtl/adc_fifo_drain_scheduler.sv
// adc_fifo_drain_scheduler: round-robin burst drain of per-channel ADC FIFOs
// into one {channel, sample} stream, with sticky overflow flags and a word counter.
module adc_fifo_drain_scheduler
   import adc_ctrl_pkg::*;
#(
   parameter int NUM_CHANNELS = 4,
   parameter int DATA_WIDTH   = 12,
   parameter int RD_LATENCY   = 1,
   parameter int BURST_LEN    = 4,
   localparam int CH_W = ch_w(NUM_CHANNELS)
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       enable,
   input  logic [NUM_CHANNELS-1:0]    fifo_not_empty,
   input  logic [NUM_CHANNELS-1:0]    fifo_full,
   input  logic [DATA_WIDTH-1:0]      fifo_dout,
   output logic [CH_W-1:0]            fifo_addr,
   output logic [NUM_CHANNELS-1:0]    fifo_rd_en,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [CH_W+DATA_WIDTH-1:0] m_data,
   output logic                       m_last,
   input  logic                       clear_sticky,
   output logic [NUM_CHANNELS-1:0]    ovf_sticky,
   output logic [31:0]                words_out
);
   localparam int BW = $clog2(BURST_LEN + 1);
   localparam int WW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   drain_state_t            state_q, state_d;
   logic [CH_W-1:0]         addr_q, addr_d;
   logic [BW-1:0]           burst_q, burst_d;
   logic [WW-1:0]           wait_q, wait_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    last_q, last_d;
   logic [NUM_CHANNELS-1:0] ovf_q, ovf_d;
   logic [31:0]             words_q, words_d;
   logic [CH_W-1:0]         grant;
   logic                    any_req, load;
   assign load = (state_q == IDLE) && enable && any_req;
   rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
      .clk(clk), .rstn(rstn), .req(fifo_not_empty), .load(load),
      .grant(grant), .any_req(any_req)
   );
   assign fifo_addr  = addr_q;
   assign fifo_rd_en = (state_q == READ) ? (NUM_CHANNELS'(1) << addr_q) : '0;
   assign m_valid    = state_q == OUT;
   assign m_data     = {addr_q, data_q};
   assign m_last     = m_valid && last_q;
   assign ovf_sticky = ovf_q;
   assign words_out  = words_q;
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      burst_d = burst_q;
      wait_d  = wait_q;
      data_d  = data_q;
      last_d  = last_q;
      ovf_d   = (clear_sticky ? '0 : ovf_q) | fifo_full;
      words_d = words_q + 32'(m_valid && m_ready);
      case (state_q)
         IDLE: if (load) begin
            state_d = READ;
            addr_d  = grant;
            burst_d = '0;
         end
         READ: begin
            state_d = WAIT;
            wait_d  = '0;
         end
         WAIT: if (wait_q == WW'(RD_LATENCY - 1)) begin
            state_d = OUT;
            data_d  = fifo_dout;
            last_d  = (burst_q + BW'(1) == BW'(BURST_LEN)) || !fifo_not_empty[addr_q] || !enable;
         end else begin
            wait_d = wait_q + WW'(1);
         end
         OUT: if (m_ready) begin
            burst_d = burst_q + BW'(1);
            // Continue the burst only while the channel still has data and grants are allowed.
            state_d = ((burst_q + BW'(1) < BW'(BURST_LEN)) && fifo_not_empty[addr_q] && enable) ? READ : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         addr_q  <= '0;
         burst_q <= '0;
         wait_q  <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         ovf_q   <= '0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         burst_q <= burst_d;
         wait_q  <= wait_d;
         data_q  <= data_d;
         last_q  <= last_d;
         ovf_q   <= ovf_d;
         words_q <= words_d;
      end
   end
endmodule
